// File: rtl/systolic_operand_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_operand_feeder_pkg
//  Description : Shared types and helpers for the systolic operand feeder:
//                FSM state encoding, buffer-select constants, clog2 helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package systolic_operand_feeder_pkg;

  // Operation FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // wr_sel values
  localparam logic WR_SEL_A = 1'b0;
  localparam logic WR_SEL_B = 1'b1;

  // Ceiling log2, never less than 1 so that derived port widths stay legal
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_operand_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_operand_feeder_if
//  Description : Bus bundle between the array controller / loader (master)
//                and the operand feeder (slave): buffer write port, start /
//                busy, load strobe with per-lane enables, streamed operands.
//  Revision    : 1.0 - initial release
// ============================================================================
interface systolic_operand_feeder_if
  import systolic_operand_feeder_pkg::*;
#(
  parameter int N  = 2,
  parameter int M  = 2,
  parameter int K  = 4,
  parameter int DW = 8
);
  localparam int LW = clog2((N > M) ? N : M);
  localparam int AW = clog2(K);

  logic            wr_en;
  logic            wr_sel;
  logic [LW-1:0]   wr_lane;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            start;
  logic            busy;
  logic            load;
  logic [N-1:0]    A_start_en;
  logic [M-1:0]    B_start_en;
  logic            finished;
  logic [N*DW-1:0] a_out;
  logic [N-1:0]    a_valid;
  logic [M*DW-1:0] b_out;
  logic [M-1:0]    b_valid;

  modport master (
    output wr_en, wr_sel, wr_lane, wr_addr, wr_data, start, load,
           A_start_en, B_start_en,
    input  busy, finished, a_out, a_valid, b_out, b_valid
  );

  modport slave (
    input  wr_en, wr_sel, wr_lane, wr_addr, wr_data, start, load,
           A_start_en, B_start_en,
    output busy, finished, a_out, a_valid, b_out, b_valid
  );

endinterface
`default_nettype wire

// File: rtl/systolic_operand_feeder_lane.sv
`default_nettype none
// ============================================================================
//  Module      : feeder_lane
//  Description : One operand lane: K-entry buffer, saturating read pointer
//                and registered output with valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module feeder_lane
  import systolic_operand_feeder_pkg::*;
#(
  parameter int K  = 4,
  parameter int DW = 8,
  localparam int AW = clog2(K)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          clr,        // restart pointer for a new operation
  input  wire logic          run,        // FSM is in RUN
  input  wire logic          load,
  input  wire logic          en,
  input  wire logic          wr_en,      // already qualified by lane/buffer/state
  input  wire logic [AW-1:0] wr_addr,
  input  wire logic [DW-1:0] wr_data,
  output logic [DW-1:0]      data_out,
  output logic               valid_out,
  output logic               lane_done,
  output logic               lane_done_next
);

  localparam int PW = clog2(K + 1);
  localparam logic [PW-1:0] c_k_ptr  = PW'(K);
  localparam logic [AW:0]   c_k_addr = (AW + 1)'(K);

  logic [DW-1:0] r_mem [K];
  logic [PW-1:0] r_ptr;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          w_issue;
  logic [PW-1:0] w_ptr_inc;

  assign w_issue        = run && load && en && (r_ptr != c_k_ptr);
  assign w_ptr_inc      = r_ptr + PW'(1);
  assign lane_done      = (r_ptr == c_k_ptr);
  assign lane_done_next = w_issue ? (w_ptr_inc == c_k_ptr) : lane_done;
  assign data_out       = r_data;
  assign valid_out      = r_valid;

  // Buffer write; out-of-range element indices are dropped, contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < c_k_addr)) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Pointer advance and one-cycle registered issue of the current element
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (clr) begin
        r_ptr <= '0;
      end else if (w_issue) begin
        r_ptr <= w_ptr_inc;
      end
      if (w_issue) begin
        r_data  <= r_mem[r_ptr];
        r_valid <= 1'b1;
      end else begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/systolic_operand_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_operand_feeder
//  Description : Holds A-row / B-column operands and streams one element per
//                lane on each controller load pulse; flags finished once
//                lane A0 has issued all K elements.
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_operand_feeder
  import systolic_operand_feeder_pkg::*;
#(
  parameter int N  = 2,
  parameter int M  = 2,
  parameter int K  = 4,
  parameter int DW = 8
) (
  input  wire logic               clk,
  input  wire logic               rst,
  systolic_operand_feeder_if.slave bus
);

  localparam int LW = clog2((N > M) ? N : M);

  state_t               r_state;
  state_t               w_next;
  logic                 r_finished;
  logic                 w_run;
  logic                 w_clr;
  logic                 w_wr_ok;
  logic [N-1:0]         w_a_done;
  logic [N-1:0]         w_a_done_next;
  logic [M-1:0]         w_b_done;
  logic [M-1:0]         w_b_done_next;
  logic [N-1:0][DW-1:0] w_a_data;
  logic [M-1:0][DW-1:0] w_b_data;
  logic [N-1:0]         w_a_valid;
  logic [M-1:0]         w_b_valid;

  assign w_run   = (r_state == ST_RUN);
  assign w_clr   = bus.start && !w_run;
  assign w_wr_ok = bus.wr_en && !w_run;

  assign bus.busy     = w_run;
  assign bus.finished = r_finished;
  assign bus.a_out    = w_a_data;
  assign bus.a_valid  = w_a_valid;
  assign bus.b_out    = w_b_data;
  assign bus.b_valid  = w_b_valid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: start launches RUN from IDLE/DONE; RUN ends when all lanes are drained
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_next = ST_RUN;
      ST_RUN:  if ((&w_a_done) && (&w_b_done)) w_next = ST_DONE;
      ST_DONE: if (bus.start) w_next = ST_RUN;
      default: w_next = ST_IDLE;
    endcase
  end

  // finished rises with the last lane-0 issue and holds until the next start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_finished <= 1'b0;
    end else if (w_clr) begin
      r_finished <= 1'b0;
    end else if (w_run && w_a_done_next[0]) begin
      r_finished <= 1'b1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_a_lane
    feeder_lane #(.K(K), .DW(DW)) u_lane (
      .clk            (clk),
      .rst            (rst),
      .clr            (w_clr),
      .run            (w_run),
      .load           (bus.load),
      .en             (bus.A_start_en[i]),
      .wr_en          (w_wr_ok && (bus.wr_sel == WR_SEL_A) && (bus.wr_lane == LW'(i))),
      .wr_addr        (bus.wr_addr),
      .wr_data        (bus.wr_data),
      .data_out       (w_a_data[i]),
      .valid_out      (w_a_valid[i]),
      .lane_done      (w_a_done[i]),
      .lane_done_next (w_a_done_next[i])
    );
  end

  for (genvar j = 0; j < M; j++) begin : g_b_lane
    feeder_lane #(.K(K), .DW(DW)) u_lane (
      .clk            (clk),
      .rst            (rst),
      .clr            (w_clr),
      .run            (w_run),
      .load           (bus.load),
      .en             (bus.B_start_en[j]),
      .wr_en          (w_wr_ok && (bus.wr_sel == WR_SEL_B) && (bus.wr_lane == LW'(j))),
      .wr_addr        (bus.wr_addr),
      .wr_data        (bus.wr_data),
      .data_out       (w_b_data[j]),
      .valid_out      (w_b_valid[j]),
      .lane_done      (w_b_done[j]),
      .lane_done_next (w_b_done_next[j])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_operand_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_operand_feeder
//  Description : Directed self-checking bench for systolic_operand_feeder
//                (N=2, M=3, K=3, DW=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_operand_feeder;
  import systolic_operand_feeder_pkg::*;

  localparam int N  = 2;
  localparam int M  = 3;
  localparam int K  = 3;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  systolic_operand_feeder_if #(.N(N), .M(M), .K(K), .DW(DW)) bus ();

  systolic_operand_feeder #(.N(N), .M(M), .K(K), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Expected streams: mode 0 = skewed enables, mode 1 = overrun (all enabled)
  logic [1:0]  t_a_en  [2][5] = '{'{2'b01, 2'b11, 2'b11, 2'b10, 2'b00},
                                  '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11}};
  logic [2:0]  t_b_en  [2][5] = '{'{3'b001, 3'b011, 3'b111, 3'b110, 3'b100},
                                  '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111}};
  logic [15:0] t_a_out [2][5] = '{'{16'h0001, 16'h0402, 16'h0503, 16'h0600, 16'h0000},
                                  '{16'h0401, 16'h0502, 16'h0603, 16'h0000, 16'h0000}};
  logic [1:0]  t_a_v   [2][5] = '{'{2'b01, 2'b11, 2'b11, 2'b10, 2'b00},
                                  '{2'b11, 2'b11, 2'b11, 2'b00, 2'b00}};
  logic [23:0] t_b_out [2][5] = '{'{24'h000007, 24'h000A08, 24'h0D0B09, 24'h0E0C00, 24'h0F0000},
                                  '{24'h0D0A07, 24'h0E0B08, 24'h0F0C09, 24'h000000, 24'h000000}};
  logic [2:0]  t_b_v   [2][5] = '{'{3'b001, 3'b011, 3'b111, 3'b110, 3'b100},
                                  '{3'b111, 3'b111, 3'b111, 3'b000, 3'b000}};
  logic        t_fin   [2][5] = '{'{1'b0, 1'b0, 1'b1, 1'b1, 1'b1},
                                  '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1}};
  logic        t_busy  [2][5] = '{'{1'b1, 1'b1, 1'b1, 1'b1, 1'b1},
                                  '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input int lane, input int addr, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_lane = lane[1:0];
    bus.wr_addr = addr[1:0];
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, " a_out"},   32'(bus.a_out),   32'h0);
    chk({name, " b_out"},   32'(bus.b_out),   32'h0);
    chk({name, " a_valid"}, 32'(bus.a_valid), 32'h0);
    chk({name, " b_valid"}, 32'(bus.b_valid), 32'h0);
  endtask

  // Start (with a load in the same cycle, which must be ignored) then five loads
  task automatic run_seq(input int mode, input bit gate_wr, input string name);
    bus.start      = 1'b1;
    bus.load       = 1'b1;
    bus.A_start_en = 2'b11;
    bus.B_start_en = 3'b111;
    tick();
    bus.start = 1'b0;
    chk({name, " start busy"},     32'(bus.busy),     32'h1);
    chk({name, " start finished"}, 32'(bus.finished), 32'h0);
    chk({name, " start valid"},    32'({bus.a_valid, bus.b_valid}), 32'h0);
    if (gate_wr) begin
      bus.wr_en   = 1'b1;
      bus.wr_sel  = WR_SEL_A;
      bus.wr_lane = 2'd0;
      bus.wr_addr = 2'd2;
      bus.wr_data = 8'hFF;
    end
    for (int s = 0; s < 5; s++) begin
      bus.load       = 1'b1;
      bus.A_start_en = t_a_en[mode][s];
      bus.B_start_en = t_b_en[mode][s];
      tick();
      chk($sformatf("%s a_out[%0d]", name, s),    32'(bus.a_out),    32'(t_a_out[mode][s]));
      chk($sformatf("%s a_valid[%0d]", name, s),  32'(bus.a_valid),  32'(t_a_v[mode][s]));
      chk($sformatf("%s b_out[%0d]", name, s),    32'(bus.b_out),    32'(t_b_out[mode][s]));
      chk($sformatf("%s b_valid[%0d]", name, s),  32'(bus.b_valid),  32'(t_b_v[mode][s]));
      chk($sformatf("%s finished[%0d]", name, s), 32'(bus.finished), 32'(t_fin[mode][s]));
      chk($sformatf("%s busy[%0d]", name, s),     32'(bus.busy),     32'(t_busy[mode][s]));
    end
    bus.wr_en      = 1'b0;
    bus.load       = 1'b0;
    bus.A_start_en = '0;
    bus.B_start_en = '0;
    tick();
    chk({name, " done busy"},     32'(bus.busy),     32'h0);
    chk({name, " done finished"}, 32'(bus.finished), 32'h1);
    chk_idle_outputs({name, " done"});
  endtask

  initial begin
    bus.wr_en      = 1'b0;
    bus.wr_sel     = 1'b0;
    bus.wr_lane    = '0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.start      = 1'b0;
    bus.load       = 1'b0;
    bus.A_start_en = '0;
    bus.B_start_en = '0;
    tick();
    tick();
    chk("reset busy",     32'(bus.busy),     32'h0);
    chk("reset finished", 32'(bus.finished), 32'h0);
    chk_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Preload operands
    for (int e = 0; e < K; e++) begin
      wr(WR_SEL_A, 0, e, 8'(1 + e));
      wr(WR_SEL_A, 1, e, 8'(4 + e));
      wr(WR_SEL_B, 0, e, 8'(7 + e));
      wr(WR_SEL_B, 1, e, 8'(10 + e));
      wr(WR_SEL_B, 2, e, 8'(13 + e));
    end
    // Out-of-range writes must not land anywhere (A lane 2 exists only for B)
    wr(WR_SEL_A, 2, 0, 8'hEE);
    wr(WR_SEL_A, 2, 2, 8'hEE);
    wr(WR_SEL_A, 0, 3, 8'hEE);
    wr(WR_SEL_B, 2, 3, 8'hEE);

    run_seq(0, 1'b0, "run1");
    run_seq(0, 1'b1, "wrgate");
    run_seq(1, 1'b0, "overrun");
    run_seq(0, 1'b0, "rerun");

    // Asynchronous reset in the middle of an operation
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      bus.load       = 1'b1;
      bus.A_start_en = t_a_en[0][s];
      bus.B_start_en = t_b_en[0][s];
      tick();
    end
    chk("midrst pre finished", 32'(bus.finished), 32'h1);
    chk("midrst pre a_valid",  32'(bus.a_valid),  32'h3);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst busy",     32'(bus.busy),     32'h0);
    chk("midrst finished", 32'(bus.finished), 32'h0);
    chk_idle_outputs("midrst");
    bus.load       = 1'b0;
    bus.A_start_en = '0;
    bus.B_start_en = '0;
    tick();
    rst = 1'b0;
    tick();
    chk("postrst busy", 32'(bus.busy), 32'h0);
    run_seq(0, 1'b0, "postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
